// File: rtl/seed_tree_expander.sv
// Seed-tree expander: walks the internal nodes breadth-first, hashes each parent seed with the
// salt through the external SM3 stage and stores both child seeds; leaves are read combinationally.
module seed_tree_expander #(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [127:0]     root_seed,
    input  logic [255:0]     salt,
    output logic             busy,
    output logic             done,
    output logic             hash_start,
    output logic [511:0]     hash_block,
    input  logic [255:0]     hash_value,
    input  logic             hash_done,
    input  logic [DEPTH-1:0] leaf_idx,
    output logic [127:0]     leaf_seed
);

    localparam int              NUM_NODES = 2**(DEPTH+1) - 1;
    localparam int              NW        = DEPTH + 1;
    localparam logic [NW-1:0]   LAST_INT  = NW'(2**DEPTH - 2);
    localparam logic [NW-1:0]   LEAF_BASE = NW'(2**DEPTH - 1);
    localparam logic [63:0]     MSG_BITS  = 64'd400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_REQ,
        S_NEXT,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   node_idx_q, node_idx_d;
    logic [255:0]    salt_q, salt_d;
    logic [511:0]    hash_block_q, hash_block_d;
    logic [127:0]    node_q [NUM_NODES];
    logic [127:0]    node_d [NUM_NODES];
    logic [NW-1:0]   child_l, child_r, leaf_addr;

    assign child_l   = {node_idx_q[NW-2:0], 1'b1};
    assign child_r   = child_l + NW'(1);
    assign leaf_addr = LEAF_BASE + {1'b0, leaf_idx};

    always_comb begin
        // NOTE: every signal assigned here gets its default first, so no path can infer a latch.
        state_d      = state_q;
        node_idx_d   = node_idx_q;
        salt_d       = salt_q;
        hash_block_d = hash_block_q;
        node_d       = node_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    node_d[0]  = root_seed;
                    salt_d     = salt;
                    node_idx_d = '0;
                    state_d    = S_CLR;
                end
            end
            // A completion flag left over from the previous node must drop before a new request.
            S_CLR: begin
                if (!hash_done) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                hash_block_d = {node_q[node_idx_q], salt_q, {(16-NW){1'b0}}, node_idx_q,
                                1'b1, 47'b0, MSG_BITS};
                state_d      = S_REQ;
            end
            S_REQ: begin
                if (hash_done) begin
                    node_d[child_l] = hash_value[255:128];
                    node_d[child_r] = hash_value[127:0];
                    state_d         = S_NEXT;
                end
            end
            S_NEXT: begin
                if (node_idx_q == LAST_INT) begin
                    state_d = S_FIN;
                end else begin
                    node_idx_d = node_idx_q + NW'(1);
                    state_d    = S_CLR;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the node array is reset with the control state so an aborted run leaves no partial tree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            node_idx_q   <= '0;
            salt_q       <= '0;
            hash_block_q <= '0;
            node_q       <= '{default: '0};
        end else begin
            // NOTE: non-blocking updates keep every flop reading the pre-edge value of the others.
            state_q      <= state_d;
            node_idx_q   <= node_idx_d;
            salt_q       <= salt_d;
            hash_block_q <= hash_block_d;
            node_q       <= node_d;
        end
    end

    assign busy       = (state_q == S_CLR) || (state_q == S_LOAD) ||
                        (state_q == S_REQ) || (state_q == S_NEXT);
    assign done       = (state_q == S_FIN);
    assign hash_start = (state_q == S_REQ);
    assign hash_block = hash_block_q;
    assign leaf_seed  = node_q[leaf_addr];

endmodule

// File: tb/tb_seed_tree_expander.sv
// Directed bench for seed_tree_expander: a DEPTH=1 and a DEPTH=3 instance, each served by a
// mock hash stage that answers {P, ~P} for parent seed P five cycles after the request.
module tb_seed_tree_expander;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] root_seed = '0;
    logic [255:0] salt = '0;

    logic         start1 = 1'b0;
    logic         busy1, done1, hs1;
    logic [511:0] hb1;
    logic [255:0] hv1 = '0;
    logic         hd1 = 1'b0;
    logic [0:0]   leaf_idx1 = '0;
    logic [127:0] leaf1;

    logic         start3 = 1'b0;
    logic         busy3, done3, hs3;
    logic [511:0] hb3;
    logic [255:0] hv3 = '0;
    logic         hd3 = 1'b0;
    logic [2:0]   leaf_idx3 = '0;
    logic [127:0] leaf3;

    int checks = 0;
    int errors = 0;

    // mock controls
    logic stale = 1'b0;
    int   extra_hold = 0;
    int   cnt1 = 0, cnt3 = 0, hold3 = 0;

    // monitor state
    logic         hs1_prev = 1'b0, hs3_prev = 1'b0, hd3_prev = 1'b0;
    logic [511:0] blk1_cap = '0, blk3_prev = '0;
    logic [255:0] exp_salt = '0;
    logic [15:0]  req_log [$];
    int req_cnt1 = 0, done_cnt1 = 0;
    int req_cnt3 = 0, done_cnt3 = 0, cap_cnt3 = 0, viol3 = 0, salt_bad3 = 0;

    always #5 clk = ~clk;

    seed_tree_expander #(.DEPTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .root_seed(root_seed), .salt(salt),
        .busy(busy1), .done(done1), .hash_start(hs1), .hash_block(hb1),
        .hash_value(hv1), .hash_done(hd1), .leaf_idx(leaf_idx1), .leaf_seed(leaf1)
    );

    seed_tree_expander #(.DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .root_seed(root_seed), .salt(salt),
        .busy(busy3), .done(done3), .hash_start(hs3), .hash_block(hb3),
        .hash_value(hv3), .hash_done(hd3), .leaf_idx(leaf_idx3), .leaf_seed(leaf3)
    );

    // mock hash stage for the DEPTH=1 instance
    always @(posedge clk) begin
        if (hs1 && !hd1) begin
            if (cnt1 == 4) begin
                hd1  <= 1'b1;
                hv1  <= {hb1[511:384], ~hb1[511:384]};
                cnt1 <= 0;
            end else begin
                cnt1 <= cnt1 + 1;
            end
        end else if (!hs1) begin
            cnt1 <= 0;
            hd1  <= 1'b0;
        end
    end

    // mock hash stage for the DEPTH=3 instance, with stale-flag and extra-hold options
    always @(posedge clk) begin
        if (stale) begin
            hd3 <= 1'b1;
        end else if (hs3) begin
            if (!hd3) begin
                if (cnt3 == 4) begin
                    hd3   <= 1'b1;
                    hv3   <= {hb3[511:384], ~hb3[511:384]};
                    cnt3  <= 0;
                    hold3 <= extra_hold;
                end else begin
                    cnt3 <= cnt3 + 1;
                end
            end
        end else begin
            cnt3 <= 0;
            if (hd3) begin
                if (hold3 == 0) hd3 <= 1'b0;
                else            hold3 <= hold3 - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (hs1 && !hs1_prev) begin
            blk1_cap = hb1;
            req_cnt1++;
        end
        if (done1) done_cnt1++;
        hs1_prev = hs1;
    end

    // protocol monitor: request log, salt field, handshake invariants, captures, done pulses
    always @(negedge clk) begin
        if (hs3 && !hs3_prev) begin
            if (hd3) viol3++;
            req_log.push_back(hb3[127:112]);
            req_cnt3++;
            if (hb3[383:128] !== exp_salt) salt_bad3++;
            blk3_prev = hb3;
        end else if (hs3 && (hb3 !== blk3_prev)) begin
            viol3++;
        end
        if (!hs3 && hs3_prev && reset) begin
            if (!hd3_prev) viol3++;
            cap_cnt3++;
        end
        if (done3) done_cnt3++;
        hs3_prev = hs3;
        hd3_prev = hd3;
    end

    // reference: the mock maps parent P to children (P, ~P)
    function automatic logic [127:0] model_leaf(input logic [127:0] r, input int k);
        logic [127:0] n [15];
        n[0] = r;
        for (int i = 0; i < 7; i++) begin
            n[2*i+1] = n[i];
            n[2*i+2] = ~n[i];
        end
        return n[7+k];
    endfunction

    task automatic pulse_start3(input logic [127:0] r, input logic [255:0] s);
        @(negedge clk);
        root_seed = r;
        salt      = s;
        start3    = 1'b1;
        @(negedge clk);
        start3    = 1'b0;
    endtask

    task automatic wait_done3(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (done3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_req3(input int target, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (req_cnt3 >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy3); end
        checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done3); end
        checks++; if (hs3 !== 1'b0) begin errors++; $display("FAIL reset_hash_start: got %b want 0", hs3); end
        checks++; if (hb3 !== 512'h0) begin errors++; $display("FAIL reset_hash_block: got %h want 0", hb3); end
        checks++; if (hb1 !== 512'h0) begin errors++; $display("FAIL reset_hash_block_d1: got %h want 0", hb1); end
        for (int k = 0; k < 8; k++) begin
            leaf_idx3 = 3'(k);
            #1;
            checks++;
            if (leaf3 !== 128'h0) begin errors++; $display("FAIL reset_leaf%0d: got %h want 0", k, leaf3); end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_depth1();
        logic [127:0] r;
        logic [511:0] exp_blk;
        int  rbase, dbase;
        bit  ok;
        r       = 128'h00112233445566778899AABBCCDDEEFF;
        exp_blk = {r, 256'h0, 16'h0000, 1'b1, 47'h0, 64'h190};
        rbase   = req_cnt1;
        dbase   = done_cnt1;
        @(negedge clk);
        root_seed = r;
        salt      = '0;
        start1    = 1'b1;
        @(negedge clk);
        start1    = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL d1_done_timeout: got no done want done"); end
        repeat (3) @(negedge clk);
        checks++; if (blk1_cap !== exp_blk) begin errors++; $display("FAIL d1_block: got %h want %h", blk1_cap, exp_blk); end
        checks++; if (req_cnt1 - rbase !== 1) begin errors++; $display("FAIL d1_req_count: got %0d want 1", req_cnt1 - rbase); end
        checks++; if (done_cnt1 - dbase !== 1) begin errors++; $display("FAIL d1_done_count: got %0d want 1", done_cnt1 - dbase); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL d1_busy_after: got %b want 0", busy1); end
        leaf_idx1 = 1'b0;
        #1;
        checks++; if (leaf1 !== r) begin errors++; $display("FAIL d1_leaf0: got %h want %h", leaf1, r); end
        leaf_idx1 = 1'b1;
        #1;
        checks++; if (leaf1 !== ~r) begin errors++; $display("FAIL d1_leaf1: got %h want %h", leaf1, ~r); end
    endtask

    task automatic test_depth3();
        logic [127:0] r;
        int  rbase, dbase, cbase, vbase, sbase;
        bit  ok;
        r        = 128'h1;
        exp_salt = {32{8'hA5}};
        rbase = req_cnt3; dbase = done_cnt3; cbase = cap_cnt3; vbase = viol3; sbase = salt_bad3;
        pulse_start3(r, exp_salt);
        wait_done3(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL d3_done_timeout: got no done want done"); end
        repeat (3) @(negedge clk);
        checks++; if (req_cnt3 - rbase !== 7) begin errors++; $display("FAIL d3_req_count: got %0d want 7", req_cnt3 - rbase); end
        for (int k = 0; k < 7; k++) begin
            if (rbase + k < req_log.size()) begin
                checks++;
                if (req_log[rbase+k] !== 16'(k)) begin
                    errors++; $display("FAIL d3_req_order%0d: got %0d want %0d", k, req_log[rbase+k], k);
                end
            end
        end
        checks++; if (salt_bad3 - sbase !== 0) begin errors++; $display("FAIL d3_salt_field: got %0d bad want 0", salt_bad3 - sbase); end
        checks++; if (viol3 - vbase !== 0) begin errors++; $display("FAIL d3_handshake: got %0d violations want 0", viol3 - vbase); end
        checks++; if (cap_cnt3 - cbase !== 7) begin errors++; $display("FAIL d3_captures: got %0d want 7", cap_cnt3 - cbase); end
        checks++; if (done_cnt3 - dbase !== 1) begin errors++; $display("FAIL d3_done_count: got %0d want 1", done_cnt3 - dbase); end
        for (int k = 0; k < 8; k++) begin
            leaf_idx3 = 3'(k);
            #1;
            checks++;
            if (leaf3 !== model_leaf(r, k)) begin errors++; $display("FAIL d3_leaf%0d: got %h want %h", k, leaf3, model_leaf(r, k)); end
        end
    endtask

    task automatic test_stale_done();
        logic [127:0] r;
        int  rbase, vbase, hs_seen;
        bit  ok;
        r        = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
        exp_salt = {16{16'h3C5A}};
        rbase = req_cnt3; vbase = viol3;
        @(negedge clk);
        stale = 1'b1;
        pulse_start3(r, exp_salt);
        hs_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (hs3) hs_seen++;
        end
        checks++; if (hs_seen !== 0) begin errors++; $display("FAIL stale_hash_start: got %0d high cycles want 0", hs_seen); end
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL stale_busy: got %b want 1", busy3); end
        stale = 1'b0;
        wait_done3(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stale_done_timeout: got no done want done"); end
        repeat (2) @(negedge clk);
        checks++; if (req_cnt3 - rbase !== 7) begin errors++; $display("FAIL stale_req_count: got %0d want 7", req_cnt3 - rbase); end
        checks++; if (viol3 - vbase !== 0) begin errors++; $display("FAIL stale_handshake: got %0d violations want 0", viol3 - vbase); end
        for (int k = 0; k < 8; k++) begin
            leaf_idx3 = 3'(k);
            #1;
            checks++;
            if (leaf3 !== model_leaf(r, k)) begin errors++; $display("FAIL stale_leaf%0d: got %h want %h", k, leaf3, model_leaf(r, k)); end
        end
    endtask

    task automatic test_start_while_busy();
        logic [127:0] ra, rb;
        int  rbase, dbase, sbase;
        bit  ok;
        ra       = 128'h0123456789ABCDEF_FEDCBA9876543210;
        rb       = 128'hFFFF0000FFFF0000_AAAA5555AAAA5555;
        exp_salt = {8{32'h0F1E2D3C}};
        rbase = req_cnt3; dbase = done_cnt3; sbase = salt_bad3;
        pulse_start3(ra, exp_salt);
        wait_req3(rbase + 3, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_req3_timeout: got %0d reqs want 3", req_cnt3 - rbase); end
        pulse_start3(rb, ~exp_salt);
        wait_done3(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_done_timeout: got no done want done"); end
        // start raised during the done cycle must also be ignored
        root_seed = rb;
        start3    = 1'b1;
        @(negedge clk);
        start3    = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL fin_start_busy: got %b want 0", busy3); end
        checks++; if (req_cnt3 - rbase !== 7) begin errors++; $display("FAIL busy_req_count: got %0d want 7", req_cnt3 - rbase); end
        checks++; if (done_cnt3 - dbase !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", done_cnt3 - dbase); end
        checks++; if (salt_bad3 - sbase !== 0) begin errors++; $display("FAIL busy_salt_resampled: got %0d bad want 0", salt_bad3 - sbase); end
        for (int k = 0; k < 8; k++) begin
            leaf_idx3 = 3'(k);
            #1;
            checks++;
            if (leaf3 !== model_leaf(ra, k)) begin errors++; $display("FAIL busy_leaf%0d: got %h want %h", k, leaf3, model_leaf(ra, k)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] rc, rd;
        int  rbase, dbase;
        bit  ok;
        rc       = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;
        rd       = 128'h89ABCDEF_01234567_76543210_FEDCBA98;
        exp_salt = {4{64'h1122334455667788}};
        rbase = req_cnt3; dbase = done_cnt3;
        pulse_start3(rc, exp_salt);
        wait_req3(rbase + 3, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_req3_timeout: got %0d reqs want 3", req_cnt3 - rbase); end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (hs3 !== 1'b0) begin errors++; $display("FAIL rst_hash_start: got %b want 0", hs3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy3); end
        checks++; if (hb3 !== 512'h0) begin errors++; $display("FAIL rst_hash_block: got %h want 0", hb3); end
        for (int k = 0; k < 8; k++) begin
            leaf_idx3 = 3'(k);
            #1;
            checks++;
            if (leaf3 !== 128'h0) begin errors++; $display("FAIL rst_leaf%0d: got %h want 0", k, leaf3); end
        end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt3 - dbase !== 0) begin errors++; $display("FAIL rst_done_pulse: got %0d want 0", done_cnt3 - dbase); end
        #2;
        reset = 1'b1;
        rbase = req_cnt3;
        pulse_start3(rd, exp_salt);
        wait_done3(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_rerun_timeout: got no done want done"); end
        repeat (2) @(negedge clk);
        checks++; if (req_cnt3 - rbase !== 7) begin errors++; $display("FAIL rst_rerun_reqs: got %0d want 7", req_cnt3 - rbase); end
        for (int k = 0; k < 8; k++) begin
            leaf_idx3 = 3'(k);
            #1;
            checks++;
            if (leaf3 !== model_leaf(rd, k)) begin errors++; $display("FAIL rst_rerun_leaf%0d: got %h want %h", k, leaf3, model_leaf(rd, k)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] re, rf;
        int  rbase, dbase, cbase, vbase;
        bit  ok;
        re         = 128'hA0A1A2A3A4A5A6A7_A8A9AAABACADAEAF;
        rf         = 128'h5F5E5D5C5B5A5958_5756555453525150;
        exp_salt   = {2{128'hC3C3C3C3_96969696_69696969_3C3C3C3C}};
        extra_hold = 4;
        rbase = req_cnt3; dbase = done_cnt3; cbase = cap_cnt3; vbase = viol3;
        pulse_start3(re, exp_salt);
        wait_done3(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_done_timeout: got no done want done"); end
        checks++; if (req_cnt3 - rbase !== 7) begin errors++; $display("FAIL hold_req_count: got %0d want 7", req_cnt3 - rbase); end
        checks++; if (cap_cnt3 - cbase !== 7) begin errors++; $display("FAIL hold_captures: got %0d want 7", cap_cnt3 - cbase); end
        for (int k = 0; k < 8; k++) begin
            leaf_idx3 = 3'(k);
            #1;
            checks++;
            if (leaf3 !== model_leaf(re, k)) begin errors++; $display("FAIL hold_leaf%0d: got %h want %h", k, leaf3, model_leaf(re, k)); end
        end
        // second run starts straight from IDLE while the last hash_done may still be high
        rbase = req_cnt3;
        pulse_start3(rf, exp_salt);
        wait_done3(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got no done want done"); end
        repeat (8) @(negedge clk);
        checks++; if (req_cnt3 - rbase !== 7) begin errors++; $display("FAIL b2b_req_count: got %0d want 7", req_cnt3 - rbase); end
        checks++; if (viol3 - vbase !== 0) begin errors++; $display("FAIL b2b_handshake: got %0d violations want 0", viol3 - vbase); end
        checks++; if (done_cnt3 - dbase !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt3 - dbase); end
        for (int k = 0; k < 8; k++) begin
            leaf_idx3 = 3'(k);
            #1;
            checks++;
            if (leaf3 !== model_leaf(rf, k)) begin errors++; $display("FAIL b2b_leaf%0d: got %h want %h", k, leaf3, model_leaf(rf, k)); end
        end
        extra_hold = 0;
    endtask

    initial begin
        test_reset();
        test_depth1();
        test_depth3();
        test_stale_done();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
